// File: rtl/sn_uart_tx_buffer.sv
// Byte FIFO feeding sn_uart_tx one byte per tx_enable/tx_done handshake.
// Define SN_TX_BUF_OVF_CNT_EN to add the saturating ovf_count output.
module sn_uart_tx_buffer #(
    parameter int P_DEPTH      = 16,
    parameter int P_DATA_WIDTH = 8,
    parameter int P_GAP_CLKS   = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [P_DATA_WIDTH-1:0]   wr_data,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(P_DEPTH):0]  level,
    output logic                      overflow,
    output logic                      tx_enable,
    output logic [P_DATA_WIDTH-1:0]   data_to_pc,
    input  logic                      tx_done,
    input  logic                      tx_active
`ifdef SN_TX_BUF_OVF_CNT_EN
    ,
    output logic [15:0]               ovf_count
`endif
);

    localparam int AW = $clog2(P_DEPTH);
    localparam int GW = $clog2(P_GAP_CLKS + 1);
    localparam logic [GW-1:0] GAP_INIT = GW'(P_GAP_CLKS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    logic [P_DATA_WIDTH-1:0] mem_q [P_DEPTH];

    state_t                  state_q, state_d;
    logic [AW:0]             wr_ptr_q, wr_ptr_d;
    logic [AW:0]             rd_ptr_q, rd_ptr_d;
    logic [GW-1:0]           cnt_q, cnt_d;
    logic                    tx_enable_q, tx_enable_d;
    logic [P_DATA_WIDTH-1:0] data_q, data_d;
    logic                    overflow_q, overflow_d;
    logic                    push;
    logic                    drop;

    // Extra pointer MSB distinguishes full from empty when indices match.
    always_comb begin
        full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        empty = (wr_ptr_q == rd_ptr_q);
        level = wr_ptr_q - rd_ptr_q;
        push  = wr_en && !full;
        drop  = wr_en && full;
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q + (AW + 1)'(push);
        overflow_d  = overflow_q | drop;
        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        tx_enable_d = tx_enable_q;
        data_d      = data_q;
        unique case (state_q)
            S_IDLE: begin
                if (!empty && !tx_active) begin
                    data_d      = mem_q[rd_ptr_q[AW-1:0]];
                    rd_ptr_d    = rd_ptr_q + (AW + 1)'(1);
                    tx_enable_d = 1'b1;
                    state_d     = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (tx_done) begin
                    tx_enable_d = 1'b0;
                    cnt_d       = GAP_INIT;
                    state_d     = S_GAP;
                end
            end
            S_GAP: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - GW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            tx_enable_q <= 1'b0;
            data_q      <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            tx_enable_q <= tx_enable_d;
            data_q      <= data_d;
            overflow_q  <= overflow_d;
        end
    end

    assign tx_enable  = tx_enable_q;
    assign data_to_pc = data_q;
    assign overflow   = overflow_q;

`ifdef SN_TX_BUF_OVF_CNT_EN
    logic [15:0] ovf_cnt_q, ovf_cnt_d;

    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (drop && (ovf_cnt_q != 16'hFFFF)) begin
            ovf_cnt_d = ovf_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ovf_cnt_q <= '0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign ovf_count = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_sn_uart_tx_buffer.sv
// Scoreboard bench for sn_uart_tx_buffer with an emulated sn_uart_tx responder.
// Honours SN_TX_BUF_OVF_CNT_EN when defined.
module tb_sn_uart_tx_buffer;

    localparam int DEPTH = 16;
    localparam int DW    = 8;
    localparam int GAP   = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          full;
    logic          empty;
    logic [4:0]    level;
    logic          overflow;
    logic          tx_enable;
    logic [DW-1:0] data_to_pc;
    logic          tx_done;
    logic          tx_active;
`ifdef SN_TX_BUF_OVF_CNT_EN
    logic [15:0]   ovf_count;
`endif

    logic resp_active  = 1'b0;
    logic resp_done    = 1'b0;
    logic force_active = 1'b0;
    logic stray_done   = 1'b0;

    assign tx_active = resp_active | force_active;
    assign tx_done   = resp_done | stray_done;

    always #5 clk = ~clk;

    sn_uart_tx_buffer #(
        .P_DEPTH(DEPTH),
        .P_DATA_WIDTH(DW),
        .P_GAP_CLKS(GAP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wr_en(wr_en),
        .wr_data(wr_data),
        .full(full),
        .empty(empty),
        .level(level),
        .overflow(overflow),
        .tx_enable(tx_enable),
        .data_to_pc(data_to_pc),
        .tx_done(tx_done),
        .tx_active(tx_active)
`ifdef SN_TX_BUF_OVF_CNT_EN
        ,
        .ovf_count(ovf_count)
`endif
    );

    int checks = 0;
    int passes = 0;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, exp);
    endtask

    // Reference model: queue of accepted bytes in send order.
    logic [DW-1:0] mq[$];
    bit            m_ovf     = 0;
    int            m_ovf_cnt = 0;
    bit            rst_e     = 0;
    bit            done_e    = 0;
    bit            can_start_e = 0;

    always @(posedge clk) begin
        rst_e       = rst;
        done_e      = tx_done;
        can_start_e = rst && (mq.size() > 0) && !tx_active;
        if (!rst) begin
            mq.delete();
            m_ovf     = 0;
            m_ovf_cnt = 0;
        end else if (wr_en) begin
            if (mq.size() < DEPTH) mq.push_back(wr_data);
            else begin
                m_ovf = 1;
                if (m_ovf_cnt < 65535) m_ovf_cnt++;
            end
        end
    end

    // Monitor: pops the scoreboard on each new request, checks timing rules.
    bit            prev_te  = 0;
    logic [DW-1:0] cur_byte = '0;
    int            low_cnt  = GAP + 1;

    always @(negedge clk) begin
        if (!rst_e) begin
            chk("rst_tx_enable", tx_enable, 0);
            chk("rst_empty", empty, 1);
            chk("rst_full", full, 0);
            chk("rst_level", level, 0);
            chk("rst_overflow", overflow, 0);
            chk("rst_data", data_to_pc, 0);
            low_cnt = GAP + 1;
        end else begin
            if (prev_te) begin
                chk("te_hold", tx_enable, !done_e);
                if (tx_enable) chk("data_hold", data_to_pc, cur_byte);
                else low_cnt = 1;
            end else if (tx_enable) begin
                chk("start_gap", low_cnt >= GAP + 1, 1);
                chk("start_cond", can_start_e, 1);
                if (mq.size() > 0) begin
                    cur_byte = mq.pop_front();
                    chk("byte_order", data_to_pc, cur_byte);
                end
            end else begin
                if (low_cnt < 100000) low_cnt++;
                if (low_cnt >= GAP + 2 && can_start_e)
                    chk("stall", tx_enable, 1);
            end
            chk("level", level, mq.size());
            chk("full", full, mq.size() == DEPTH);
            chk("empty", empty, mq.size() == 0);
            chk("overflow", overflow, m_ovf);
`ifdef SN_TX_BUF_OVF_CNT_EN
            chk("ovf_count", ovf_count, m_ovf_cnt);
`endif
        end
        prev_te = tx_enable;
    end

    // Emulated serializer: busy for a few clocks, then one tx_done pulse.
    bit resp_rand = 1;
    int resp_len  = 3;
    int rcnt      = 0;
    bit busy      = 0;

    initial begin
        forever begin
            @(posedge clk);
            #2;
            resp_done = 1'b0;
            if (!rst) begin
                busy        = 0;
                resp_active = 1'b0;
            end else if (busy) begin
                if (rcnt == 0) begin
                    resp_done   = 1'b1;
                    resp_active = 1'b0;
                    busy        = 0;
                end else rcnt--;
            end else if (tx_enable) begin
                busy        = 1;
                resp_active = 1'b1;
                rcnt = resp_rand ? int'($urandom_range(0, 12)) : resp_len;
            end
        end
    end

    task automatic push(input logic [DW-1:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            wr_en = 1'b0;
        end
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while ((mq.size() != 0 || tx_enable) && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (k >= budget) chk("drain_timeout", 1, 0);
        idle(GAP + 3);
    endtask

    task automatic wait_te(input int budget);
        int k;
        k = 0;
        while (!tx_enable && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (k >= budget) chk("wait_te_timeout", 1, 0);
    endtask

    initial begin
        int rate;
        rst     = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        idle(2);

        push(8'hF0);
        idle(1);
        drain(500);

        push(8'hA5);
        push(8'h3C);
        push(8'h7E);
        idle(1);
        drain(500);

        resp_rand = 0;
        resp_len  = 60;
        push(8'h11);
        idle(1);
        wait_te(50);
        for (int i = 0; i < 17; i++) push(DW'(8'h20 + i));
        idle(1);
        drain(5000);

        resp_len = 50;
        push(8'h51);
        push(8'h52);
        push(8'h53);
        idle(1);
        wait_te(50);
        idle(3);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        idle(3);
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        idle(6);
        resp_rand = 1;

        force_active = 1'b1;
        for (int i = 0; i < 4; i++) push(DW'(8'hC0 + i));
        idle(20);
        force_active = 1'b0;
        drain(500);

        rate = 50;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (i % 400 == 0) rate = $urandom_range(10, 95);
            wr_en        = ($urandom_range(0, 99) < rate);
            wr_data      = DW'($urandom);
            stray_done   = ($urandom_range(0, 199) == 0);
            force_active = ((i % 300) < 15);
            rst          = ($urandom_range(0, 1499) != 0);
        end
        @(negedge clk);
        wr_en        = 1'b0;
        stray_done   = 1'b0;
        force_active = 1'b0;
        rst          = 1'b1;
        drain(5000);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
